// File: rtl/nn_bus_pkg.sv
// rtl/nn_bus_pkg.sv - shared address map, status bits and FSM encoding for nn_bus_master
package nn_bus_pkg;

    localparam int ADDR_W = 9;
    localparam int IDX_W  = 5;

    localparam logic [ADDR_W-1:0] ADDR_COEFF0 = 9'd0;
    localparam logic [ADDR_W-1:0] ADDR_OFFSET = 9'd20;
    localparam logic [ADDR_W-1:0] ADDR_DATA   = 9'd21;
    localparam logic [ADDR_W-1:0] ADDR_START  = 9'd22;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 9'd23;
    localparam logic [ADDR_W-1:0] ADDR_RESULT = 9'd24;

    localparam int STATUS_DONE_BIT = 0;
    localparam int STATUS_ERR_BIT  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DATA,
        ST_START,
        ST_POLL,
        ST_RESULT,
        ST_OUT
    } state_e;

endpackage

// File: rtl/nn_coeff_shadow.sv
// rtl/nn_coeff_shadow.sv - coefficient/offset shadow register file with dirty tracking
module nn_coeff_shadow
    import nn_bus_pkg::*;
#(
    parameter int Width      = 32,
    parameter int NumEntries = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [Width-1:0] wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [Width-1:0] rdata,
    input  logic             clear_dirty,
    output logic             dirty
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NumEntries - 1);

    logic [Width-1:0] mem_q [NumEntries];
    logic [Width-1:0] mem_d [NumEntries];
    logic             dirty_q;
    logic             dirty_d;
    logic             we_ok;

    assign we_ok = we && (widx <= LastIdx);

    // A write in the same cycle as the read is forwarded, so a load that
    // starts together with a config write sees the new value.
    assign rdata = (we_ok && (widx == ridx)) ? wdata :
                   (ridx <= LastIdx)         ? mem_q[ridx] : '0;

    // Pending write counts as dirty immediately so the job-start decision
    // cannot miss it.
    assign dirty = dirty_q | we_ok;

    always_comb begin
        mem_d   = mem_q;
        dirty_d = dirty_q;
        if (we_ok) begin
            mem_d[widx] = wdata;
            dirty_d     = 1'b1;
        end
        // Clear wins: a write in the clear cycle is already in the reload
        // through the forwarding path above.
        if (clear_dirty) begin
            dirty_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumEntries; i++) begin
                mem_q[i] <= '0;
            end
            dirty_q <= 1'b1;
        end else begin
            mem_q   <= mem_d;
            dirty_q <= dirty_d;
        end
    end

endmodule

// File: rtl/nn_bus_master.sv
// rtl/nn_bus_master.sv - bus initiator that runs neuron accelerator jobs from a sample stream
module nn_bus_master
    import nn_bus_pkg::*;
#(
    parameter int Width       = 32,
    parameter int NumCoeff    = 20,
    parameter int PollTimeout = 1023
) (
    input  logic              CLK,
    input  logic              MasterReset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [Width-1:0]  cfg_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [Width-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [Width-1:0]  out_data,
    output logic              out_error,
    output logic              busy,
    output logic              write,
    output logic              read,
    output logic [ADDR_W-1:0] address,
    output logic [Width-1:0]  writedata,
    input  logic [Width-1:0]  readdata
);

    localparam int                CntW  = $clog2(PollTimeout + 1);
    localparam logic [IDX_W-1:0]  LastK = IDX_W'(NumCoeff);
    localparam logic [CntW-1:0]   CntMax = CntW'(PollTimeout);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   k_q, k_d;
    logic [Width-1:0]   sample_q, sample_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               write_q, write_d;
    logic               read_q, read_d;
    logic [ADDR_W-1:0]  address_q, address_d;
    logic [Width-1:0]   writedata_q, writedata_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [Width-1:0]   out_data_q, out_data_d;
    logic               out_error_q, out_error_d;
    logic               busy_q, busy_d;

    logic               clear_dirty;
    logic               dirty;
    logic [Width-1:0]   shadow_rdata;

    nn_coeff_shadow #(
        .Width      (Width),
        .NumEntries (NumCoeff + 1)
    ) u_shadow (
        .clk         (CLK),
        .rst_n       (MasterReset),
        .we          (cfg_we),
        .widx        (cfg_idx),
        .wdata       (cfg_data),
        .ridx        (k_d),
        .rdata       (shadow_rdata),
        .clear_dirty (clear_dirty),
        .dirty       (dirty)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        sample_d    = sample_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_error_d = out_error_q;
        clear_dirty = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (in_ready_q && in_valid) begin
                    sample_d = in_data;
                    k_d      = '0;
                    if (dirty) begin
                        state_d     = ST_LOAD;
                        clear_dirty = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_LOAD: begin
                if (k_q == LastK) begin
                    state_d = ST_DATA;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DATA: begin
                state_d = ST_START;
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_POLL;
            end
            ST_POLL: begin
                // readdata is combinational from the slave during our read.
                if (readdata[STATUS_DONE_BIT]) begin
                    out_error_d = readdata[STATUS_ERR_BIT];
                    state_d     = ST_RESULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CntMax) begin
                        out_error_d = 1'b1;
                        out_data_d  = '0;
                        state_d     = ST_OUT;
                    end
                end
            end
            ST_RESULT: begin
                out_data_d = readdata;
                state_d    = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus outputs are registered, so they are computed for the state
        // being entered and appear for exactly that state's cycle.
        write_d     = 1'b0;
        read_d      = 1'b0;
        address_d   = '0;
        writedata_d = '0;
        case (state_d)
            ST_LOAD: begin
                write_d     = 1'b1;
                address_d   = ADDR_COEFF0 + ADDR_W'(k_d);
                writedata_d = shadow_rdata;
            end
            ST_DATA: begin
                write_d     = 1'b1;
                address_d   = ADDR_DATA;
                writedata_d = sample_d;
            end
            ST_START: begin
                write_d   = 1'b1;
                address_d = ADDR_START;
            end
            ST_POLL: begin
                read_d    = 1'b1;
                address_d = ADDR_STATUS;
            end
            ST_RESULT: begin
                read_d    = 1'b1;
                address_d = ADDR_RESULT;
            end
            default: begin
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        out_valid_d = (state_d == ST_OUT);
    end

    always_ff @(posedge CLK or negedge MasterReset) begin
        if (!MasterReset) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            sample_q    <= '0;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            address_q   <= '0;
            writedata_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_error_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            sample_q    <= sample_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            read_q      <= read_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_error_q <= out_error_d;
            busy_q      <= busy_d;
        end
    end

    assign write     = write_q;
    assign read      = read_q;
    assign address   = address_q;
    assign writedata = writedata_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_error = out_error_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_nn_bus_master.sv
// tb/tb_nn_bus_master.sv - randomized self-checking bench for nn_bus_master
module tb_nn_bus_master;

    localparam int PT = 8;

    logic        CLK = 1'b0;
    logic        MasterReset;
    logic        cfg_we;
    logic [4:0]  cfg_idx;
    logic [31:0] cfg_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_error;
    logic        busy;
    logic        write;
    logic        read;
    logic [8:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit [31:0] shadow_m [21];
    bit        model_dirty = 1'b1;

    // slave model
    int          polls_seen = 0;
    int          sl_done_poll = 0;
    logic        sl_err = 1'b0;
    logic [31:0] sl_result = '0;
    int          both_hi = 0;
    logic [41:0] bus_log [$];

    always #5 CLK = ~CLK;

    nn_bus_master #(
        .Width       (32),
        .NumCoeff    (20),
        .PollTimeout (PT)
    ) dut (
        .CLK         (CLK),
        .MasterReset (MasterReset),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_data    (cfg_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_error   (out_error),
        .busy        (busy),
        .write       (write),
        .read        (read),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata)
    );

    always_comb begin
        readdata = '0;
        if (read && address == 9'd23) begin
            readdata[0] = (sl_done_poll != 0) && (polls_seen + 1 >= sl_done_poll);
            readdata[1] = sl_err;
        end else if (read && address == 9'd24) begin
            readdata = sl_result;
        end
    end

    always @(posedge CLK) begin
        if (write && address == 9'd22) polls_seen <= 0;
        else if (read && address == 9'd23) polls_seen <= polls_seen + 1;
    end

    always @(negedge CLK) begin
        if (write) bus_log.push_back({1'b1, address, writedata});
        if (read)  bus_log.push_back({1'b0, address, 32'h0});
        if (write && read) both_hi++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_cfg(input logic [4:0] idx, input logic [31:0] data);
        if (idx < 5'd21) begin
            shadow_m[idx] = data;
            model_dirty   = 1'b1;
        end
    endtask

    task automatic cfg_write(input logic [4:0] idx, input logic [31:0] data);
        cfg_we = 1'b1; cfg_idx = idx; cfg_data = data;
        @(negedge CLK);
        cfg_we = 1'b0;
        model_cfg(idx, data);
    endtask

    task automatic run_job(input logic [31:0] sample, input int done_poll, input logic err,
                           input logic [31:0] result, input int hold,
                           input bit cap_cfg, input logic [4:0] cap_idx, input logic [31:0] cap_data);
        logic [41:0] exp_q [$];
        int start, n, lat, want_lat, e0;
        bit done, was_dirty;
        logic [31:0] held;
        sl_done_poll = done_poll; sl_err = err; sl_result = result;
        for (int i = 0; i < 50 && in_ready !== 1'b1; i++) @(negedge CLK);
        chk("in_ready_idle", in_ready, 1);
        if (cap_cfg) model_cfg(cap_idx, cap_data);
        done = (done_poll != 0) && (done_poll <= PT);
        n = done ? done_poll : PT;
        was_dirty = model_dirty;
        if (model_dirty) begin
            for (int k = 0; k < 21; k++) exp_q.push_back({1'b1, 9'(k), shadow_m[k]});
            model_dirty = 1'b0;
        end
        exp_q.push_back({1'b1, 9'd21, sample});
        exp_q.push_back({1'b1, 9'd22, 32'h0});
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 9'd23, 32'h0});
        if (done) exp_q.push_back({1'b0, 9'd24, 32'h0});
        want_lat = (was_dirty ? 21 : 0) + 2 + n + (done ? 1 : 0);
        start = bus_log.size();
        in_valid = 1'b1; in_data = sample;
        if (cap_cfg) begin cfg_we = 1'b1; cfg_idx = cap_idx; cfg_data = cap_data; end
        @(negedge CLK);
        in_valid = 1'b0; in_data = $urandom;
        if (cap_cfg) cfg_we = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge CLK);
            lat++;
        end
        chk("out_valid", out_valid, 1);
        chk("latency", lat, want_lat);
        chk("out_data", out_data, done ? result : 32'h0);
        chk("out_error", out_error, done ? err : 1'b1);
        held = out_data;
        repeat (hold) @(negedge CLK);
        if (hold > 0) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, held);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        chk("bus_count", bus_log.size() - start, exp_q.size());
        e0 = errors;
        for (int i = 0; i < exp_q.size() && start + i < bus_log.size(); i++) begin
            chk($sformatf("bus[%0d]", i), bus_log[start + i], exp_q[i]);
            if (errors != e0) break;
        end
    endtask

    initial begin
        MasterReset = 1'b0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_write", write, 0);
        chk("rst_read", read, 0);
        chk("rst_address", address, 0);
        chk("rst_writedata", writedata, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_error", out_error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        MasterReset = 1'b1;
        @(negedge CLK);
        chk("post_rst_in_ready", in_ready, 1);

        // first job: full load of zeros, done on poll 3
        run_job(32'h0100_0000, 3, 1'b0, 32'h0080_0000, 0, 1'b0, 5'd0, 32'h0);
        // clean job: no load
        run_job(32'h0200_0000, 2, 1'b0, 32'h1111_2222, 0, 1'b0, 5'd0, 32'h0);
        // config write while polling forces the next job to reload
        fork
            run_job(32'h0300_0000, 6, 1'b0, 32'h3333_4444, 0, 1'b0, 5'd0, 32'h0);
            begin repeat (6) @(negedge CLK); cfg_write(5'd5, 32'h0000_1234); end
        join
        run_job(32'h0400_0000, 1, 1'b0, 32'h5555_6666, 0, 1'b0, 5'd0, 32'h0);
        // timeout, then done+error, then long out_ready stall
        run_job(32'h0500_0000, 0, 1'b0, 32'hdead_beef, 0, 1'b0, 5'd0, 32'h0);
        run_job(32'h0600_0000, 2, 1'b1, 32'h7777_8888, 0, 1'b0, 5'd0, 32'h0);
        run_job(32'h0700_0000, 4, 1'b0, 32'h9999_aaaa, 10, 1'b0, 5'd0, 32'h0);
        // write in the capture cycle lands in the reload
        run_job(32'h0800_0000, 2, 1'b0, 32'h0bad_cafe, 0, 1'b1, 5'd0, 32'h00c0_ffee);

        // reset in the middle of LOAD
        cfg_write(5'd3, 32'h0000_aaaa);
        for (int i = 0; i < 50 && in_ready !== 1'b1; i++) @(negedge CLK);
        in_valid = 1'b1; in_data = 32'h0900_0000;
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (5) @(negedge CLK);
        chk("load_write", write, 1);
        MasterReset = 1'b0;
        #1;
        chk("midrst_write", write, 0);
        chk("midrst_read", read, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        for (int k = 0; k < 21; k++) shadow_m[k] = '0;
        model_dirty = 1'b1;
        @(negedge CLK);
        MasterReset = 1'b1;
        run_job(32'h0a00_0000, 2, 1'b0, 32'h1234_5678, 0, 1'b0, 5'd0, 32'h0);

        for (int j = 0; j < 25; j++) begin
            int nw;
            bit cap;
            logic [4:0] cidx;
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++) cfg_write(5'($urandom_range(0, 23)), $urandom);
            cap = ($urandom_range(0, 3) == 0);
            cidx = $urandom_range(0, 1) ? 5'd0 : 5'($urandom_range(0, 22));
            run_job($urandom, $urandom_range(0, 10), 1'($urandom_range(0, 1)), $urandom,
                    $urandom_range(0, 3), cap, cidx, $urandom);
        end

        chk("rw_exclusive", both_hi, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nn_bus_master.md
# nn_bus_master

Bus initiator for the neural-network neuron accelerator's memory-mapped slave port. It owns the `write`/`read`/`address`/`writedata`/`readdata` side that the CPU interface would otherwise drive, so jobs run without software involvement. It shadows the 20 coefficients and the offset locally and reloads them into the accelerator only when they change. For each accepted input sample it writes the datum, pulses start, polls status until done, reads the result and presents it on a valid/ready output.

## Interface
- `Width`, 32: data word width (Q format: 1 sign, 7 magnitude, 24 fraction bits; opaque to this block).
- `NumCoeff`, 20: coefficient count; the offset is an extra entry at index `NumCoeff`.
- `PollTimeout`, 1023: maximum status polls per job before aborting.
- `CLK` in 1: single clock, rising edge.
- `MasterReset` in 1: asynchronous, active-low reset.
- `cfg_we` in 1: write one shadow entry this cycle.
- `cfg_idx` in 5: shadow index, 0..19 coefficient, 20 offset; ≥21 ignored.
- `cfg_data` in Width: shadow data.
- `in_valid`, `in_ready` in/out 1: input sample handshake.
- `in_data` in Width: input sample.
- `out_valid`, `out_ready` out/in 1: result handshake.
- `out_data` out Width: result word.
- `out_error` out 1: accelerator error bit or poll timeout, qualified by `out_valid`.
- `busy` out 1: FSM not in IDLE.
- `write`, `read` out 1: bus strobes, never both high.
- `address` out 9: bus address.
- `writedata` out Width: bus write data.
- `readdata` in Width: bus read data, combinational from the slave in the same cycle as `read`.

## Operation
- Address map: 0..19 coefficients, 20 offset, 21 input datum, 22 start (any write), 23 status (bit0 done, bit1 error), 24 result.
- Shadow RAM of 21×Width words plus a `dirty` flag. Any accepted `cfg_we` sets `dirty`.
  - Writes are accepted in any state.
  - A write landing during LOAD keeps `dirty` set so the reload repeats on the next job.
- FSM states: IDLE, LOAD, DATA, START, POLL, RESULT, OUT.
  - IDLE: `in_ready`=1. On `in_valid`, capture `in_data`. Go to LOAD if `dirty`, else DATA. On entry to LOAD, clear `dirty`.
  - LOAD: one write per cycle, address k = 0..20, `writedata` = shadow[k]. After k = 20, go to DATA.
  - DATA: one write to address 21 with the captured sample, then START.
  - START: one write to address 22, data 0. Clear the poll counter, go to POLL.
  - POLL: `read`=1 at address 23 every cycle, sampling `readdata` the same cycle.
    - bit0=1: latch bit1 as error and go to RESULT.
    - Otherwise increment the counter. When the counter reaches `PollTimeout`, set error, force result 0 and go to OUT.
  - RESULT: one read at address 24, latch `readdata`, go to OUT.
  - OUT: `out_valid`=1 holding the result and error. On `out_ready`, go to IDLE.
- Reset values: all bus outputs 0; `in_ready` 0 during reset and 1 in IDLE afterwards; `out_valid` 0; `out_data` 0; `out_error` 0; `busy` 0; `dirty` 1 (forces a first load); shadow contents 0.
- Reset asserted mid-job: the FSM returns to IDLE immediately, the bus strobes drop asynchronously, and `dirty` is set.

## Timing
- Bus strobes, address and data are registered; one transfer per cycle with no wait states.
- Clean job (not dirty) with done seen on poll n: DATA 1 + START 1 + POLL n + RESULT 1 cycles, then `out_valid` the following cycle.
- A dirty job adds 21 cycles of LOAD.
- `in_ready` is high only in IDLE. Back-to-back jobs need at least one IDLE cycle between an OUT handshake and the next capture.
- `cfg_we` in the same cycle as IDLE capture: the write lands in the shadow before LOAD reads it, and the bypass is handled by setting `dirty` before the LOAD/DATA decision.

## Structure
- Shared package `nn_bus_pkg` holds:
  - the address constants (ADDR_COEFF0=0, ADDR_OFFSET=20, ADDR_DATA=21, ADDR_START=22, ADDR_STATUS=23, ADDR_RESULT=24);
  - the status bit positions;
  - the FSM state encoding.
- One sub-module, `nn_coeff_shadow`: 21-entry register file with one write port, one read port and `dirty` tracking.

## Test plan
- After reset, no config writes, one sample 0x0100_0000; slave returns done on poll 3 and result 0x0080_0000 → 21 LOAD writes of 0, then writes to 21 and 22, 3 status reads, one result read; `out_data`=0x0080_0000, `out_error`=0.
- Second job with no config change → no LOAD writes; the first bus write is to address 21.
- `cfg_we` idx 5 = 0x1234 mid-POLL → the next job reloads all 21 entries and address 5 carries 0x1234.
- Slave never sets done, `PollTimeout`=8 → 8 status reads, then `out_valid` with `out_data`=0 and `out_error`=1.
- Status returns 0b11 → result read still occurs; `out_error`=1.
- `out_ready` held low for 10 cycles → `out_valid` and data stay stable, `in_ready`=0; reset asserted during LOAD → strobes drop, `busy`=0, and the next job performs a full reload.
